sram_like_arbiter: RTL

- Shares one sram-like bus port between the IF-stage instruction requester and the EXE-stage data requester.
- The bus port is req / addr_ok / data_ok with in-order responses.
- Data requests have priority. The block tracks up to OT_DEPTH outstanding transactions in an owner FIFO and routes each response to its owner.
- Responses to instruction requests in flight when the pipeline is flushed are silently discarded.

---
 rtl/sram_like_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - shares one sram-like bus port between the IF fetch and EXE data requesters
module sram_like_arbiter #(
  parameter int OT_DEPTH = 2,
  parameter int OT_AW    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        cancel,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {ARB_IDLE, ARB_HOLD_I, ARB_HOLD_D} arb_state_t;

  localparam logic [OT_AW:0] FULL_CNT = (OT_AW+1)'(OT_DEPTH);

  arb_state_t       state, state_nxt;
  logic             hold_wr;
  logic [1:0]       hold_size;
  logic [3:0]       hold_wstrb;
  logic [31:0]      hold_addr;
  logic [31:0]      hold_wdata;
  logic             orphan;
  logic             fifo_owner   [OT_DEPTH];
  logic             fifo_discard [OT_DEPTH];
  logic [OT_AW-1:0] rd_ptr, wr_ptr;
  logic [OT_AW:0]   count;

  logic             full, gnt_inst, gnt_data, req, latch;
  logic             wr;
  logic [1:0]       size;
  logic [3:0]       wstrb;
  logic [31:0]      addr, wdata;
  logic             push, pop, push_discard, head_owner, head_discard;

  assign full = (count == FULL_CNT);

  always_comb begin
    state_nxt = state;
    gnt_inst  = 1'b0;
    gnt_data  = 1'b0;
    req       = 1'b0;
    latch     = 1'b0;
    wr        = 1'b0;
    size      = 2'd0;
    wstrb     = 4'd0;
    addr      = 32'd0;
    wdata     = 32'd0;
    case (state)
      ARB_IDLE: begin
        // no pop-to-push bypass: a full FIFO blocks the grant even if a response pops this cycle
        if (!full) begin
          if (data_req) begin
            gnt_data = 1'b1;
            req      = 1'b1;
            wr       = data_wr;
            size     = data_size;
            wstrb    = data_wstrb;
            addr     = data_addr;
            wdata    = data_wdata;
          end else if (inst_req) begin
            gnt_inst = 1'b1;
            req      = 1'b1;
            size     = 2'd2;
            addr     = inst_addr;
          end
          if (req && !bus_addr_ok) begin
            latch     = 1'b1;
            state_nxt = gnt_data ? ARB_HOLD_D : ARB_HOLD_I;
          end
        end
      end
      ARB_HOLD_I, ARB_HOLD_D: begin
        gnt_inst = (state == ARB_HOLD_I);
        gnt_data = (state == ARB_HOLD_D);
        req      = 1'b1;
        wr       = hold_wr;
        size     = hold_size;
        wstrb    = hold_wstrb;
        addr     = hold_addr;
        wdata    = hold_wdata;
        if (bus_addr_ok) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign bus_req   = reset & req;
  assign bus_wr    = reset & wr;
  assign bus_size  = reset ? size  : 2'd0;
  assign bus_wstrb = reset ? wstrb : 4'd0;
  assign bus_addr  = reset ? addr  : 32'd0;
  assign bus_wdata = reset ? wdata : 32'd0;

  assign push         = bus_req & bus_addr_ok;
  assign push_discard = gnt_inst & (cancel | orphan);
  assign inst_addr_ok = push & gnt_inst & ~orphan;
  assign data_addr_ok = push & gnt_data;

  assign head_owner   = fifo_owner[rd_ptr];
  assign head_discard = fifo_discard[rd_ptr];
  assign pop          = reset & bus_data_ok & (count != '0);
  assign inst_data_ok = pop & ~head_owner & ~head_discard;
  assign data_data_ok = pop & head_owner;
  assign inst_rdata   = inst_data_ok ? bus_rdata : 32'd0;
  assign data_rdata   = data_data_ok ? bus_rdata : 32'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      hold_wr    <= 1'b0;
      hold_size  <= 2'd0;
      hold_wstrb <= 4'd0;
      hold_addr  <= 32'd0;
      hold_wdata <= 32'd0;
      orphan     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        hold_wr    <= wr;
        hold_size  <= size;
        hold_wstrb <= wstrb;
        hold_addr  <= addr;
        hold_wdata <= wdata;
      end
      // a fetch flushed while still waiting for its address phase must not be acknowledged later
      if (state == ARB_HOLD_I && bus_addr_ok) orphan <= 1'b0;
      else if (state == ARB_HOLD_I && cancel) orphan <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < OT_DEPTH; i++) begin
        fifo_owner[i]   <= 1'b0;
        fifo_discard[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < OT_DEPTH; i++) begin
        if (push && wr_ptr == OT_AW'(i)) begin
          fifo_owner[i]   <= gnt_data;
          fifo_discard[i] <= push_discard;
        end else if (cancel && !fifo_owner[i]) begin
          fifo_discard[i] <= 1'b1;
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
